// File: rtl/cpuc_ctrl_seq_pkg.sv
// Shared types and sizes for the cpuc control sequencer.
// Column 0 occupies the most significant slice of a control word, so in
// t_ctrl_word.col the array index is NUM_REGS-1-c for column c.
package cpuc_ctrl_seq_pkg;
  localparam int NUM_OF_REGS       = 4;
  localparam int NUM_OF_PC         = 1;
  localparam int NUM_OF_COMPONENTS = 8;
  localparam int PROG_DEPTH_DEF    = 16;

  localparam int NUM_REGS = NUM_OF_REGS + NUM_OF_PC;
  localparam int SEL_W    = $clog2(NUM_OF_COMPONENTS);
  localparam int PC_W     = $clog2(PROG_DEPTH_DEF);
  localparam int CW_W     = NUM_REGS*(1+SEL_W) + 1 + SEL_W + PC_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} t_seq_state;

  typedef struct packed {
    logic             valid;
    logic [SEL_W-1:0] src;
  } t_col_ctrl;

  typedef struct packed {
    t_col_ctrl [NUM_REGS-1:0] col;   // col[NUM_REGS-1] is column 0
    logic                     br_en;
    logic [SEL_W-1:0]         cond_sel;
    logic [PC_W-1:0]          br_target;
    logic                     halt;
  } t_ctrl_word;
endpackage

// File: rtl/cpuc_ctrl_seq_if.sv
// Sequencer bus: program load, run control, grid feedback and grid controls.
// master = host/grid side, slave = sequencer.
interface cpuc_ctrl_seq_if #(
  parameter int NUM_REGS   = 5,
  parameter int NUM_COMP   = 8,
  parameter int PROG_DEPTH = 16
);
  localparam int SW = $clog2(NUM_COMP);
  localparam int PW = $clog2(PROG_DEPTH);
  localparam int CW = NUM_REGS*(1+SW) + 1 + SW + PW + 1;

  logic                               prog_we;
  logic [PW-1:0]                      prog_addr;
  logic [CW-1:0]                      prog_wdata;
  logic                               start;
  logic                               stop;
  logic [NUM_COMP-1:0]                cond_in;
  logic [NUM_REGS-1:0][NUM_COMP-1:0]  sel_en;
  logic [NUM_REGS-1:0]                reg_we;
  logic [PW-1:0]                      pc_out;
  logic                               busy;
  logic                               done;
  logic                               cfg_err;

  modport master (
    output prog_we, prog_addr, prog_wdata, start, stop, cond_in,
    input  sel_en, reg_we, pc_out, busy, done, cfg_err
  );
  modport slave (
    input  prog_we, prog_addr, prog_wdata, start, stop, cond_in,
    output sel_en, reg_we, pc_out, busy, done, cfg_err
  );
endinterface

// File: rtl/cpuc_prog_mem.sv
// Control-word store: synchronous write, registered read.
// Ports: we/waddr/wdata write port; re/raddr load rdata on the clock edge.
module cpuc_prog_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 29,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/cpuc_ctrl_seq.sv
// Control sequencer for the cpuc register grid. Steps a small program of
// control words (2 cycles each: FETCH, EXEC), drives one-hot tristate
// enables and write enables per column, branches on grid feedback.
// Ports: clk, rst (sync, active high); bus (slave) carries program load,
// start/stop, cond_in feedback and sel_en/reg_we/pc_out/busy/done/cfg_err.
module cpuc_ctrl_seq
  import cpuc_ctrl_seq_pkg::*;
#(
  parameter int NUM_REGS   = NUM_OF_REGS + NUM_OF_PC,
  parameter int NUM_COMP   = NUM_OF_COMPONENTS,
  parameter int PROG_DEPTH = PROG_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  cpuc_ctrl_seq_if.slave    bus
);
  localparam int SW     = $clog2(NUM_COMP);
  localparam int PW     = $clog2(PROG_DEPTH);
  localparam int CW     = NUM_REGS*(1+SW) + 1 + SW + PW + 1;
  localparam int COL_LO = PW + SW + 2;
  localparam logic [SW:0] NCMP = (SW+1)'(NUM_COMP);

  t_seq_state state, nxt;
  logic [PW-1:0] pc;
  logic [CW-1:0] cw_q;
  logic          done_q, err_q;
  logic          idle_like, in_exec;

  assign idle_like = (state == IDLE) || (state == HALT);
  assign in_exec   = (state == EXEC);

  cpuc_prog_mem #(.DEPTH(PROG_DEPTH), .W(CW)) u_mem (
    .clk   (clk),
    .we    (bus.prog_we && idle_like),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_wdata),
    .re    (state == FETCH),
    .raddr (pc),
    .rdata (cw_q)
  );

  logic          halt, br_en, cond_ok, taken;
  logic [SW-1:0] cond_sel;
  logic [PW-1:0] br_tgt;
  logic [(1<<SW)-1:0] cpad;

  assign halt     = cw_q[0];
  assign br_tgt   = cw_q[PW:1];
  assign cond_sel = cw_q[PW+SW:PW+1];
  assign br_en    = cw_q[PW+SW+1];
  assign cond_ok  = {1'b0, cond_sel} < NCMP;

  // cond_in padded to the full select range; out-of-range selects are
  // masked by cond_ok anyway
  always_comb begin
    cpad = '0;
    cpad[NUM_COMP-1:0] = bus.cond_in;
  end
  assign taken = br_en && cond_ok && cpad[cond_sel];

  logic [NUM_REGS-1:0][NUM_COMP-1:0] sel;
  logic [NUM_REGS-1:0]               we, col_bad;

  for (genvar c = 0; c < NUM_REGS; c++) begin : g_col
    localparam int LO = COL_LO + (NUM_REGS-1-c)*(1+SW);
    logic [SW-1:0] src;
    logic          vld, ok;
    assign src = cw_q[LO +: SW];
    assign vld = cw_q[LO+SW];
    assign ok  = vld && ({1'b0, src} < NCMP);
    assign col_bad[c] = vld && !ok;
    assign we[c] = in_exec && ok;
    for (genvar i = 0; i < NUM_COMP; i++) begin : g_bit
      assign sel[c][i] = we[c] && (src == SW'(i));
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, HALT: if (bus.start) nxt = FETCH;
      FETCH:      nxt = EXEC;
      EXEC:       nxt = halt ? HALT : FETCH;
      default:    nxt = IDLE;
    endcase
    if (bus.stop) nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      done_q <= in_exec && halt && !bus.stop;
      if (bus.stop || (idle_like && bus.start)) pc <= '0;
      else if (in_exec && !halt)                pc <= taken ? br_tgt : pc + 1'b1;
      if (idle_like && bus.start && !bus.stop)                    err_q <= 1'b0;
      else if (in_exec && ((|col_bad) || (br_en && !cond_ok)))    err_q <= 1'b1;
    end
  end

  assign bus.sel_en  = sel;
  assign bus.reg_we  = we;
  assign bus.pc_out  = pc;
  assign bus.busy    = (state == FETCH) || in_exec;
  assign bus.done    = done_q;
  assign bus.cfg_err = err_q;
endmodule
